ldmstm_sequencer: RTL and testbench
===================================

Name: ldmstm_sequencer

Overview:
Multi-cycle controller for ARM block data transfers (LDM/STM). It accepts a decoded LDM/STM instruction and its base-register value from decode, then stalls the pipeline while it steps the register list one beat per memory handshake. Per beat it issues the register index and word address. It ends with an optional base writeback on the register-file write port.

Parameters:
ADDR_W, 32, address and data width; the word stride is fixed at 4.

Ports:
clk  in  1  clock; all state updates on posedge
rst_b  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
insn  in  32  LDM/STM instruction word: P=24, U=23, S=22, W=21, L=20, Rn=19:16, list=15:0
base  in  ADDR_W  Rn value (op0 from decode), captured with start
flush  in  1  synchronous pipeline flush
busy  out  1  high in every state except IDLE; drives upstream stall
done  out  1  one-cycle pulse at completion
mem_req  out  1  beat request
mem_ack  in  1  beat accepted/complete
mem_addr  out  ADDR_W  beat address, word aligned
mem_we  out  1  1=store (L=0)
mem_reg  out  4  register for this beat
mem_user  out  1  S bit (user-bank transfer)
wb_valid  out  1  base writeback strobe, one cycle
wb_reg  out  4  Rn
wb_data  out  ADDR_W  new base value
pc_loaded  out  1  one-cycle pulse with done when L=1 and r15 was in the list

Behaviour:
- Reset (rst_b low, any state): state=IDLE. All outputs are 0. Latched insn, base and list are cleared.
- States:
  - IDLE -> CALC on start.
  - CALC (1 cycle) -> XFER if list!=0, else DONE.
  - XFER -> WB or DONE after the ack of the last beat.
  - WB (1 cycle) -> DONE.
  - DONE (1 cycle) -> IDLE.
- CALC computation: n = popcount(list), 0..16. off = 4*n, 7-bit zero-extended. First address:
  - IA (P0 U1): base
  - IB (P1 U1): base+4
  - DA (P0 U0): base-off+4
  - DB (P1 U0): base-off
  - New base: U ? base+off : base-off, modulo 2^ADDR_W.
- Registers are transferred in ascending index to ascending address regardless of U.
- Latency: start is sampled at edge E0 and CALC runs in cycle E0..E1. mem_req rises after E1.
- Handshake:
  - mem_req, mem_addr, mem_reg, mem_we and mem_user are stable while mem_req=1 and mem_ack=0.
  - On a cycle with mem_req&mem_ack: clear the lowest set list bit and add 4 to mem_addr.
  - If list bits remain, mem_req stays high and the next beat presents on the next cycle, so back-to-back acks give 1 beat/cycle.
  - mem_ack is ignored when mem_req=0.
- Writeback: WB is entered only if W=1 and NOT (L=1 and Rn in list); a load of Rn supersedes writeback. An STM with Rn in the list still writes back. wb_valid is asserted in WB.
- Empty list: no beats, no writeback. done is asserted 2 cycles after start, and busy stays high for those cycles.
- start while busy: ignored, not queued.
- flush: next state is IDLE from any state. mem_req drops on the following cycle and no wb_valid or done is produced. A same-cycle mem_ack still counts as completed; the memory side tolerates the withdrawn request.
- busy is deasserted in the cycle after DONE.

Optional Feature:
MEM_ABORT_EN.
- Enabled: adds input mem_abort (1) and output aborted (1).
  - mem_abort is qualified by mem_req&mem_ack.
  - It terminates the transfer with no further beats and suppresses writeback, matching base-restored abort semantics.
  - It goes to DONE with aborted=1 for that cycle and pc_loaded=0.
- Disabled: neither port exists, and every acked beat completes normally.

Test Plan:
- LDMIA r0!,{r1,r2,r5}: insn=0xE8B00026, base=0x1000, ack every cycle -> beats (r1,0x1000), (r2,0x1004), (r5,0x1008), mem_we=0; wb r0=0x100C; done 6 cycles after start.
- STMDB r13!,{r4,r14}: insn=0xE92D4010, base=0x2000, ack held off 3 cycles per beat -> (r4,0x1FF8), (r14,0x1FFC), mem_we=1, outputs stable while waiting; wb r13=0x1FF8.
- LDMDA r2,{r0,r15} and LDMIB r2,{r0,r15} with base=0x100, W=0 -> DA: 0xFC, 0x100; IB: 0x104, 0x108; no wb_valid; pc_loaded pulses with done.
- LDMIA r1!,{r1,r2} (0xE8B10006) -> two beats, no wb_valid. Empty list (0xE8B00000) -> no mem_req, done 2 cycles after start.
- Mid-transfer: assert flush on the second beat -> mem_req low next cycle, no done or wb. Separately, pull rst_b low during XFER -> all outputs 0 immediately, IDLE; a new start afterwards runs cleanly.
- MEM_ABORT_EN: abort on the 2nd of 3 beats -> no 3rd beat, no wb, done and aborted pulse together.

Source files
------------

// File: rtl/ldmstm_sequencer.sv
// LDM/STM block-transfer sequencer: steps the register list one beat per memory handshake, then optional base writeback.
// Define MEM_ABORT_EN to add the mem_abort input and aborted output (abort ends the transfer without writeback).
module ldmstm_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic [31:0]       insn,
    input  logic [ADDR_W-1:0] base,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_reg,
    output logic              mem_user,
`ifdef MEM_ABORT_EN
    input  logic              mem_abort,
    output logic              aborted,
`endif
    output logic              wb_valid,
    output logic [3:0]        wb_reg,
    output logic [ADDR_W-1:0] wb_data,
    output logic              pc_loaded
);

    typedef enum logic [2:0] {IDLE, CALC, XFER, WB, DONE} state_t;

    state_t            state_q, state_d;
    logic [24:0]       insn_q;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       list_q;
    logic [ADDR_W-1:0] newBase_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [3:0]        memReg_q;
    logic              memReq_q, memWe_q, memUser_q;
    logic              busy_q, done_q, wbValid_q, pcLoaded_q;
    logic [3:0]        wbReg_q;
    logic [ADDR_W-1:0] wbData_q;

    logic              pBit, uBit, sBit, wBit, lBit;
    logic [3:0]        rn;
    logic [15:0]       insnList;
    logic [15:0]       rest;
    logic [ADDR_W-1:0] off, firstAddr, newBase;
    logic              beatDone, abortHit, wbNeeded;
    logic              unusedInsnBits;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction

    function automatic logic [3:0] lowestSet(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    assign unusedInsnBits = &{1'b0, insn[31:25]};

    assign pBit     = insn_q[24];
    assign uBit     = insn_q[23];
    assign sBit     = insn_q[22];
    assign wBit     = insn_q[21];
    assign lBit     = insn_q[20];
    assign rn       = insn_q[19:16];
    assign insnList = insn_q[15:0];

    assign rest     = list_q & (list_q - 16'd1);
    assign beatDone = memReq_q & mem_ack;
`ifdef MEM_ABORT_EN
    assign abortHit = beatDone & mem_abort;
`else
    assign abortHit = 1'b0;
`endif
    // A load that includes Rn overwrites the base, so the writeback is dropped.
    assign wbNeeded = wBit & ~(lBit & insnList[rn]);

    // Addresses always ascend; decrementing modes just start lower.
    always_comb begin
        off     = {{(ADDR_W-7){1'b0}}, popcount16(list_q), 2'b00};
        newBase = uBit ? base_q + off : base_q - off;
        case ({pBit, uBit})
            2'b01:   firstAddr = base_q;
            2'b11:   firstAddr = base_q + ADDR_W'(4);
            2'b00:   firstAddr = base_q - off + ADDR_W'(4);
            default: firstAddr = base_q - off;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) state_d = CALC;
                CALC: state_d = (list_q != 16'd0) ? XFER : DONE;
                XFER: begin
                    if (beatDone) begin
                        if (abortHit)           state_d = DONE;
                        else if (rest == 16'd0) state_d = wbNeeded ? WB : DONE;
                    end
                end
                WB:      state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so each pulse lines up with its state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            insn_q     <= '0;
            base_q     <= '0;
            list_q     <= '0;
            newBase_q  <= '0;
            memAddr_q  <= '0;
            memReg_q   <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memUser_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wbValid_q  <= 1'b0;
            wbReg_q    <= '0;
            wbData_q   <= '0;
            pcLoaded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != IDLE);
            memReq_q   <= (state_d == XFER);
            memWe_q    <= (state_d == XFER) & ~lBit;
            memUser_q  <= (state_d == XFER) & sBit;
            wbValid_q  <= (state_d == WB);
            wbReg_q    <= (state_d == WB) ? rn : 4'd0;
            wbData_q   <= (state_d == WB) ? newBase_q : '0;
            done_q     <= (state_d == DONE);
            pcLoaded_q <= (state_d == DONE) & ~abortHit & lBit & insnList[15];
            if (state_q == IDLE && state_d == CALC) begin
                insn_q <= insn[24:0];
                base_q <= base;
                list_q <= insn[15:0];
            end
            if (state_q == CALC) begin
                newBase_q <= newBase;
                memAddr_q <= firstAddr;
                memReg_q  <= lowestSet(list_q);
            end
            if (state_q == XFER && beatDone) begin
                list_q <= rest;
                if (rest != 16'd0) begin
                    memAddr_q <= memAddr_q + ADDR_W'(4);
                    memReg_q  <= lowestSet(rest);
                end
            end
        end
    end

`ifdef MEM_ABORT_EN
    logic aborted_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) aborted_q <= 1'b0;
        else        aborted_q <= (state_d == DONE) & abortHit;
    end

    assign aborted = aborted_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = memReq_q;
    assign mem_addr  = memAddr_q;
    assign mem_we    = memWe_q;
    assign mem_reg   = memReg_q;
    assign mem_user  = memUser_q;
    assign wb_valid  = wbValid_q;
    assign wb_reg    = wbReg_q;
    assign wb_data   = wbData_q;
    assign pc_loaded = pcLoaded_q;

endmodule

// File: tb/tb_ldmstm_sequencer.sv
// Self-checking bench for ldmstm_sequencer: table of directed transfers plus flush, reset, busy-start and abort sequences.
module tb_ldmstm_sequencer;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        start = 1'b0;
    logic [31:0] insn = '0;
    logic [31:0] base = '0;
    logic        flush = 1'b0;
    logic        busy, done, mem_req, mem_we, mem_user, wb_valid, pc_loaded;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr, wb_data;
    logic [3:0]  mem_reg, wb_reg;
`ifdef MEM_ABORT_EN
    logic        mem_abort = 1'b0;
    logic        aborted;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    ldmstm_sequencer #(.ADDR_W(32)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .insn(insn), .base(base), .flush(flush),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_reg(mem_reg), .mem_user(mem_user),
`ifdef MEM_ABORT_EN
        .mem_abort(mem_abort), .aborted(aborted),
`endif
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .pc_loaded(pc_loaded)
    );

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [31:0] base;
        int          ackDelay;
        int          expBeats;
        logic [31:0] firstAddr;
        logic        expWb;
        logic [31:0] expWbData;
        logic        expPc;
        int          expDone;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] lowestBit(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    task automatic checkAllZero(input string name);
        checkOutput({name, ".flags"}, 32'({busy, done, mem_req, mem_we, mem_user, wb_valid, pc_loaded}), 32'd0);
        checkOutput({name, ".mem_addr"}, mem_addr, 32'd0);
        checkOutput({name, ".mem_reg"}, 32'(mem_reg), 32'd0);
        checkOutput({name, ".wb"}, 32'(wb_reg) | wb_data, 32'd0);
    endtask

    // Cycle k is observed at the k-th falling edge after start was raised.
    task automatic applyStimulus(input vec_t v);
        int          cyc, waitCnt, beat, doneCycle, firstReq, wbCycle;
        logic [15:0] remaining;
        logic [3:0]  snapReg, wbRegSeen;
        logic [31:0] snapAddr, wbDataSeen;
        logic        snapWe, stableBad, busyDropped, sawPc, sawWb, expWe, expUser;
        waitCnt = 0; beat = 0; doneCycle = -1; firstReq = -1; wbCycle = -1;
        remaining = v.insn[15:0];
        snapReg = '0; snapAddr = '0; snapWe = 1'b0; stableBad = 1'b0;
        busyDropped = 1'b0; sawPc = 1'b0; sawWb = 1'b0; wbRegSeen = '0; wbDataSeen = '0;
        expWe = !v.insn[20];
        expUser = v.insn[22];
        @(negedge clk);
        insn = v.insn; base = v.base; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (doneCycle < 0 && cyc <= 60) begin
            if (!busy) busyDropped = 1'b1;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (firstReq < 0) firstReq = cyc;
                if (waitCnt == 0) begin
                    snapReg = mem_reg; snapAddr = mem_addr; snapWe = mem_we; stableBad = 1'b0;
                end else if (mem_reg !== snapReg || mem_addr !== snapAddr || mem_we !== snapWe) begin
                    stableBad = 1'b1;
                end
                if (waitCnt == v.ackDelay) begin
                    checkOutput({v.name, ".reg"}, 32'(mem_reg), 32'(lowestBit(remaining)));
                    checkOutput({v.name, ".addr"}, mem_addr, v.firstAddr + 32'(4 * beat));
                    checkOutput({v.name, ".we"}, 32'(mem_we), 32'(expWe));
                    checkOutput({v.name, ".user"}, 32'(mem_user), 32'(expUser));
                    if (v.ackDelay > 0) checkOutput({v.name, ".stable"}, 32'(stableBad), 32'd0);
                    remaining = remaining & (remaining - 16'd1);
                    beat++;
                    waitCnt = 0;
                    mem_ack = 1'b1;
                end else begin
                    waitCnt++;
                end
            end
            if (wb_valid) begin
                sawWb = 1'b1; wbCycle = cyc; wbRegSeen = wb_reg; wbDataSeen = wb_data;
            end
            if (done) begin
                doneCycle = cyc;
                sawPc = pc_loaded;
            end
            @(negedge clk);
            cyc++;
        end
        mem_ack = 1'b0;
        checkOutput({v.name, ".beats"}, 32'(beat), 32'(v.expBeats));
        if (v.expBeats > 0) checkOutput({v.name, ".firstReqCycle"}, 32'(firstReq), 32'd2);
        checkOutput({v.name, ".doneCycle"}, 32'(doneCycle), 32'(v.expDone));
        checkOutput({v.name, ".wbValid"}, 32'(sawWb), 32'(v.expWb));
        if (sawWb) begin
            checkOutput({v.name, ".wbReg"}, 32'(wbRegSeen), 32'(v.insn[19:16]));
            checkOutput({v.name, ".wbData"}, wbDataSeen, v.expWbData);
            checkOutput({v.name, ".wbBeforeDone"}, 32'(wbCycle + 1), 32'(doneCycle));
        end
        checkOutput({v.name, ".pcLoaded"}, 32'(sawPc), 32'(v.expPc));
        checkOutput({v.name, ".busyHeld"}, 32'(busyDropped), 32'd0);
        checkOutput({v.name, ".busyAfter"}, 32'(busy), 32'd0);
    endtask

    task automatic flushSequence();
        logic sawAny;
        sawAny = 1'b0;
        @(negedge clk);
        insn = 32'hE8B00026; base = 32'h1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("flush.req1", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        checkOutput("flush.reg2", 32'(mem_reg), 32'd2);
        mem_ack = 1'b1; flush = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; flush = 1'b0;
        checkOutput("flush.reqDrop", 32'(mem_req), 32'd0);
        checkOutput("flush.busy", 32'(busy), 32'd0);
        repeat (6) begin
            if (done || wb_valid || mem_req) sawAny = 1'b1;
            @(negedge clk);
        end
        checkOutput("flush.quiet", 32'(sawAny), 32'd0);
    endtask

    task automatic resetSequence();
        @(negedge clk);
        insn = 32'hE92D4010; base = 32'h2000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("reset.reqBefore", 32'(mem_req), 32'd1);
        #2 rst_b = 1'b0;
        #1 checkAllZero("reset.xfer");
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic busyStartSequence();
        @(negedge clk);
        insn = 32'hE8B00000; base = 32'h4000; start = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        insn = 32'hE8B00026; base = 32'h1000;
        checkOutput("busyStart.calcBusy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("busyStart.done", 32'(done), 32'd1);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyStart.idle1", 32'({busy, mem_req}), 32'd0);
        @(negedge clk);
        checkOutput("busyStart.idle2", 32'({busy, mem_req}), 32'd0);
        mem_ack = 1'b0;
    endtask

`ifdef MEM_ABORT_EN
    task automatic abortSequence();
        @(negedge clk);
        insn = 32'hE8B08006; base = 32'h1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("abort.reg1", 32'(mem_reg), 32'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        checkOutput("abort.addr2", mem_addr, 32'h1004);
        mem_ack = 1'b1; mem_abort = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; mem_abort = 1'b0;
        checkOutput("abort.done", 32'({done, aborted}), 32'h3);
        checkOutput("abort.noPcWbReq", 32'({pc_loaded, wb_valid, mem_req}), 32'd0);
        @(negedge clk);
        checkOutput("abort.after", 32'({busy, mem_req, aborted, done}), 32'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{"ldmia_r0_wb",   32'hE8B00026, 32'h1000, 0, 3,  32'h1000, 1'b1, 32'h100C,     1'b0, 6};
        vecs[1] = '{"stmdb_r13_wb",  32'hE92D4010, 32'h2000, 3, 2,  32'h1FF8, 1'b1, 32'h1FF8,     1'b0, 11};
        vecs[2] = '{"ldmda_pc",      32'hE8128001, 32'h0100, 0, 2,  32'h00FC, 1'b0, 32'h0,        1'b1, 4};
        vecs[3] = '{"ldmib_pc",      32'hE9928001, 32'h0100, 1, 2,  32'h0104, 1'b0, 32'h0,        1'b1, 6};
        vecs[4] = '{"ldmia_rn_list", 32'hE8B10006, 32'h3000, 0, 2,  32'h3000, 1'b0, 32'h0,        1'b0, 4};
        vecs[5] = '{"empty_list",    32'hE8B00000, 32'h4000, 0, 0,  32'h0,    1'b0, 32'h0,        1'b0, 2};
        vecs[6] = '{"stmia_user_rn", 32'hE8E10006, 32'h5000, 0, 2,  32'h5000, 1'b1, 32'h5008,     1'b0, 5};
        vecs[7] = '{"stmda_wrap",    32'hE8230003, 32'h0004, 2, 2,  32'h0000, 1'b1, 32'hFFFFFFFC, 1'b0, 9};
        vecs[8] = '{"stmib_full",    32'hE9A0FFFF, 32'h0100, 0, 16, 32'h0104, 1'b1, 32'h0140,     1'b0, 19};
        vecs[9] = '{"ldmdb_full",    32'hE910FFFF, 32'h1000, 0, 16, 32'h0FC0, 1'b0, 32'h0,        1'b1, 18};

        repeat (2) @(negedge clk);
        checkAllZero("reset.initial");
        rst_b = 1'b1;

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        flushSequence();
        applyStimulus(vecs[0]);
        resetSequence();
        applyStimulus(vecs[0]);
        busyStartSequence();
`ifdef MEM_ABORT_EN
        abortSequence();
        applyStimulus(vecs[0]);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
